// File: rtl/audio_in_onset_detector.sv
// ---------------------------------------------------------------------------
// audio_in_onset_detector
//
// Consumer side of the Audio_Controller capture FIFO. Pops stereo ADC sample
// pairs whenever they are available, rectifies them, follows a peak envelope
// with exponential release and turns envelope onsets into one-cycle drum
// trigger pulses carrying the captured peak level.
//
// Pipeline (N = pop cycle):
//   N+1 : rectified magnitude max(|L|,|R|) registered (v1)
//   N+2 : envelope updated (v2)
//   N+3 : threshold/peak/holdoff FSM result (hit, hit_level, busy)
//
// Ports:
//   CLOCK_50               in   system clock, rising edge
//   reset                  in   asynchronous, active-high
//   enable                 in   gates popping; in-flight samples still finish
//   threshold       [31:0] in   unsigned trigger level
//   audio_in_available     in   capture FIFO non-empty (show-ahead data)
//   left_channel_audio_in  [31:0] in  signed left sample
//   right_channel_audio_in [31:0] in  signed right sample
//   read_audio_in          out  pop strobe to the capture FIFO
//   envelope        [31:0] out  current envelope
//   hit                    out  one-cycle onset pulse
//   hit_level       [31:0] out  peak envelope of the most recent hit
//   busy                   out  high whenever the FSM is not ARMED
// ---------------------------------------------------------------------------
module audio_in_onset_detector #(
  parameter int unsigned DECAY_SHIFT      = 4,
  parameter int unsigned HOLDOFF_SAMPLES  = 4800,
  parameter int unsigned PEAK_MAX_SAMPLES = 96
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] threshold,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [31:0] envelope,
  output logic        hit,
  output logic [31:0] hit_level,
  output logic        busy
);

  localparam int unsigned HCNT_W = (HOLDOFF_SAMPLES  > 1) ? $clog2(HOLDOFF_SAMPLES + 1)  : 1;
  localparam int unsigned PCNT_W = (PEAK_MAX_SAMPLES > 1) ? $clog2(PEAK_MAX_SAMPLES + 1) : 1;

  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLDOFF_SAMPLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(PEAK_MAX_SAMPLES);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PEAK    = 2'd1,
    HOLDOFF = 2'd2,
    REARM   = 2'd3
  } state_t;

  // Two's-complement magnitude; the most negative value has no positive
  // counterpart and saturates.
  function automatic logic [31:0] sat_abs(input logic [31:0] x);
    if (!x[31]) begin
      return x;
    end else if (x == 32'h8000_0000) begin
      return 32'h7FFF_FFFF;
    end else begin
      return (~x) + 32'd1;
    end
  endfunction

  logic              pop;
  logic [31:0]       abs_l, abs_r;

  logic [31:0]       mag_q,       mag_d;
  logic              v1_q,        v1_d;
  logic [31:0]       env_q,       env_d;
  logic              v2_q,        v2_d;
  state_t            state_q,     state_d;
  logic [31:0]       pk_q,        pk_d;
  logic [PCNT_W-1:0] pcnt_q,      pcnt_d;
  logic [HCNT_W-1:0] hcnt_q,      hcnt_d;
  logic              hit_q,       hit_d;
  logic [31:0]       hit_level_q, hit_level_d;

  assign pop = audio_in_available & enable & ~reset;

  assign abs_l = sat_abs(left_channel_audio_in);
  assign abs_r = sat_abs(right_channel_audio_in);

  // Stage 1: rectify and take the louder channel.
  always_comb begin
    mag_d = mag_q;
    v1_d  = pop;
    if (pop) begin
      mag_d = (abs_l > abs_r) ? abs_l : abs_r;
    end
  end

  // Stage 2: instant attack, exponential release. The subtracted term is a
  // fraction of env itself, so env can never underflow; small values stall.
  always_comb begin
    env_d = env_q;
    v2_d  = v1_q;
    if (v1_q) begin
      if (mag_q > env_q) begin
        env_d = mag_q;
      end else begin
        env_d = env_q - (env_q >> DECAY_SHIFT);
      end
    end
  end

  // Onset FSM, stepped once per processed sample (v2 strobe).
  always_comb begin
    state_d     = state_q;
    pk_d        = pk_q;
    pcnt_d      = pcnt_q;
    hcnt_d      = hcnt_q;
    hit_d       = 1'b0;
    hit_level_d = hit_level_q;
    if (v2_q) begin
      case (state_q)
        ARMED: begin
          if (env_q >= threshold) begin
            state_d = PEAK;
            pk_d    = env_q;
            pcnt_d  = PCNT_W'(1);
          end
        end
        PEAK: begin
          // A falling envelope or an over-long rise both terminate the peak;
          // the reported level is the peak tracked so far.
          if ((env_q < pk_q) || (pcnt_q == PCNT_MAX)) begin
            hit_d       = 1'b1;
            hit_level_d = pk_q;
            hcnt_d      = '0;
            state_d     = HOLDOFF;
          end else begin
            pk_d   = env_q;
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        HOLDOFF: begin
          if (hcnt_q == HCNT_LAST) begin
            state_d = REARM;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        REARM: begin
          // Hysteresis: re-arm only once the envelope has fallen well below
          // the trigger level.
          if (env_q < (threshold >> 1)) begin
            state_d = ARMED;
          end
        end
        default: begin
          state_d = ARMED;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mag_q       <= '0;
      v1_q        <= 1'b0;
      env_q       <= '0;
      v2_q        <= 1'b0;
      state_q     <= ARMED;
      pk_q        <= '0;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      hit_q       <= 1'b0;
      hit_level_q <= '0;
    end else begin
      mag_q       <= mag_d;
      v1_q        <= v1_d;
      env_q       <= env_d;
      v2_q        <= v2_d;
      state_q     <= state_d;
      pk_q        <= pk_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      hit_q       <= hit_d;
      hit_level_q <= hit_level_d;
    end
  end

  assign read_audio_in = pop;
  assign envelope      = env_q;
  assign hit           = hit_q;
  assign hit_level     = hit_level_q;
  assign busy          = (state_q != ARMED);

endmodule

// File: tb/tb_audio_in_onset_detector.sv
module tb_audio_in_onset_detector;

  localparam int DS   = 4;
  localparam int HOLD = 4;
  localparam int PMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] thr;
  logic        avail;
  logic [31:0] lch, rch;
  logic        read_audio_in;
  logic [31:0] envelope;
  logic        hit;
  logic [31:0] hit_level;
  logic        busy;

  always #5 clk = ~clk;

  audio_in_onset_detector #(
    .DECAY_SHIFT(DS),
    .HOLDOFF_SAMPLES(HOLD),
    .PEAK_MAX_SAMPLES(PMAX)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .enable(en),
    .threshold(thr),
    .audio_in_available(avail),
    .left_channel_audio_in(lch),
    .right_channel_audio_in(rch),
    .read_audio_in(read_audio_in),
    .envelope(envelope),
    .hit(hit),
    .hit_level(hit_level),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hits_seen = 0;
  int rd_seen = 0;

  // ---------------- behavioural reference ----------------
  // Sample-level model: envelope as plain arithmetic, detector as a few
  // descriptive flags/counters; results are time-stamped by pop cycle.
  logic [31:0] m_env, m_pk, m_hl;
  int          m_pn, m_hold_left;
  bit          m_in_peak, m_wait_rearm;

  logic [31:0] env_sched [int];
  logic [31:0] hl_sched  [int];
  bit          hit_sched [int];
  bit          busy_sched[int];
  logic [31:0] e_env, e_hl;
  bit          e_busy;

  function automatic logic [31:0] mag_of(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_env = 0; m_pk = 0; m_hl = 0; m_pn = 0; m_hold_left = 0;
    m_in_peak = 0; m_wait_rearm = 0;
    env_sched.delete(); hl_sched.delete(); hit_sched.delete(); busy_sched.delete();
    e_env = 0; e_hl = 0; e_busy = 0;
  endtask

  task automatic model_pop(input logic [31:0] l, input logic [31:0] r, input int p);
    logic [31:0] mag;
    bit h;
    mag = (mag_of(l) > mag_of(r)) ? mag_of(l) : mag_of(r);
    if (mag > m_env) m_env = mag;
    else m_env = m_env - (m_env / (32'd1 << DS));
    h = 0;
    if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_wait_rearm = 1;
    end else if (m_wait_rearm) begin
      if (m_env < thr / 2) m_wait_rearm = 0;
    end else if (!m_in_peak) begin
      if (m_env >= thr) begin m_in_peak = 1; m_pk = m_env; m_pn = 1; end
    end else begin
      if (m_env < m_pk || m_pn == PMAX) begin
        h = 1; m_hl = m_pk; m_in_peak = 0; m_hold_left = HOLD;
      end else begin
        m_pk = m_env; m_pn++;
      end
    end
    env_sched[p+1]  = m_env;
    hit_sched[p+2]  = h;
    hl_sched[p+2]   = m_hl;
    busy_sched[p+2] = m_in_peak || (m_hold_left > 0) || m_wait_rearm;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit e_hit;
    if (env_sched.exists(cyc))  begin e_env  = env_sched[cyc];  env_sched.delete(cyc);  end
    if (hl_sched.exists(cyc))   begin e_hl   = hl_sched[cyc];   hl_sched.delete(cyc);   end
    if (busy_sched.exists(cyc)) begin e_busy = busy_sched[cyc]; busy_sched.delete(cyc); end
    e_hit = 0;
    if (hit_sched.exists(cyc)) begin e_hit = hit_sched[cyc]; hit_sched.delete(cyc); end
    check32("envelope",  envelope,         e_env);
    check32("hit",       {31'b0, hit},     {31'b0, e_hit});
    check32("hit_level", hit_level,        e_hl);
    check32("busy",      {31'b0, busy},    {31'b0, e_busy});
    if (hit === 1'b1) hits_seen++;
  endtask

  // One clock: drive at the negedge, check pop strobe, check outputs at the
  // following negedge.
  task automatic tick(input bit av, input logic [31:0] l, input logic [31:0] r);
    bit exp_rd;
    avail = av; lch = l; rch = r;
    #1;
    exp_rd = av & en & ~rst;
    check32("read_audio_in", {31'b0, read_audio_in}, {31'b0, exp_rd});
    if (read_audio_in === 1'b1) rd_seen++;
    if (exp_rd) model_pop(l, r, cyc + 1);
    @(posedge clk); cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; avail = 1'b1;
    #1;
    check32("rst_envelope",  envelope,               32'd0);
    check32("rst_hit",       {31'b0, hit},           32'd0);
    check32("rst_hit_level", hit_level,              32'd0);
    check32("rst_busy",      {31'b0, busy},          32'd0);
    check32("rst_read",      {31'b0, read_audio_in}, 32'd0);
    model_reset();
    @(posedge clk); cyc++;
    @(negedge clk);
    rst = 1'b0; avail = 1'b0;
  endtask

  function automatic logic [31:0] rand_sample();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom_range(0, 2000);
      1: v = $urandom_range(0, 20000);
      2: v = $urandom;
      3: v = 32'd0;
      default: v = 32'h8000_0000;
    endcase
    if ($urandom_range(0, 1) == 1) v = (~v) + 32'd1;
    return v;
  endfunction

  typedef struct {
    bit          rst_first;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_env;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int h0;
    vecs[0]  = '{1'b1, 32'hFFFF_FC18, 32'd700,      32'd1000};
    vecs[1]  = '{1'b0, 32'd0,         32'd1600,     32'd1600};
    vecs[2]  = '{1'b0, 32'd0,         32'd0,        32'd1500};
    vecs[3]  = '{1'b0, 32'd0,         32'd0,        32'd1407};
    vecs[4]  = '{1'b0, 32'd0,         32'd0,        32'd1320};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'd5,        32'h7FFF_FFFF};
    vecs[6]  = '{1'b0, 32'd0,         32'd0,        32'h7800_0000};
    vecs[7]  = '{1'b1, 32'd10,        32'hFFFF_FFFD, 32'd10};
    vecs[8]  = '{1'b0, 32'd0,         32'd0,        32'd10};
    vecs[9]  = '{1'b0, 32'd0,         32'd0,        32'd10};
    vecs[10] = '{1'b0, 32'd0,         32'hFFFF_FFF0, 32'd16};
    vecs[11] = '{1'b0, 32'd0,         32'd0,        32'd15};
    vecs[12] = '{1'b0, 32'd7,         32'h8000_0001, 32'h7FFF_FFFF};

    rst = 1'b1; en = 1'b1; thr = '1; avail = 1'b0; lch = '0; rch = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Rectify / saturate / decay table (threshold unreachable).
    thr = '1;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst_first) do_reset();
      tick(1'b1, vecs[i].l, vecs[i].r);
      tick(1'b0, 32'd0, 32'd0);
      check32($sformatf("vec%0d_env", i), envelope, vecs[i].exp_env);
    end

    // Handshake with and without enable.
    do_reset();
    rd_seen = 0;
    for (int i = 1; i <= 5; i++) tick(1'b1, 32'd0, 32'(i * 100));
    idle(3);
    check32("hs_pops_en", rd_seen, 32'd5);
    check32("hs_env_en", envelope, 32'd500);
    en = 1'b0; rd_seen = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 32'd9000, 32'd9000);
    idle(3);
    check32("hs_pops_dis", rd_seen, 32'd0);
    check32("hs_env_dis", envelope, 32'd500);
    en = 1'b1;

    // Onset: mags 0,500,2000,3000,2500.
    do_reset();
    thr = 32'd1000; hits_seen = 0;
    tick(1'b1, 32'd0, 32'd0);
    tick(1'b1, 32'd500, 32'd0);
    tick(1'b1, 32'd0, 32'hFFFF_F830);
    tick(1'b1, 32'd3000, 32'd0);
    tick(1'b1, 32'd2500, 32'd100);
    tick(1'b0, 32'd0, 32'd0);
    check32("onset_pre_hit", {31'b0, hit}, 32'd0);
    check32("onset_env", envelope, 32'd2813);
    tick(1'b0, 32'd0, 32'd0);
    check32("onset_hit", {31'b0, hit}, 32'd1);
    check32("onset_level", hit_level, 32'd3000);
    check32("onset_busy", {31'b0, busy}, 32'd1);
    tick(1'b0, 32'd0, 32'd0);
    check32("onset_pulse_end", {31'b0, hit}, 32'd0);

    // Holdoff swallows a loud sample; REARM holds while env >= thr/2.
    tick(1'b1, 32'd5000, 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b1, 32'd600, 32'd0);
    idle(3);
    check32("rearm_hits", hits_seen, 32'd1);
    check32("rearm_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 40; i++) tick(1'b1, 32'd0, 32'd0);
    idle(3);
    check32("rearm_exit_busy", {31'b0, busy}, 32'd0);
    tick(1'b1, 32'd2000, 32'd0);
    tick(1'b1, 32'd0, 32'd0);
    idle(3);
    check32("second_hit", hits_seen, 32'd2);
    check32("second_level", hit_level, 32'd2000);

    // Forced hit after PMAX samples of rising envelope.
    do_reset();
    thr = 32'd1000; hits_seen = 0;
    for (int i = 0; i < 12; i++) tick(1'b1, 32'(1000 + 100 * i), 32'd0);
    idle(3);
    check32("forced_hits", hits_seen, 32'd1);
    check32("forced_level", hit_level, 32'd1700);

    // Reset while a hit is pending in PEAK.
    do_reset();
    thr = 32'd1000; hits_seen = 0;
    tick(1'b1, 32'd2000, 32'd0);
    tick(1'b1, 32'd3000, 32'd0);
    tick(1'b1, 32'd2500, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    check32("pend_busy", {31'b0, busy}, 32'd1);
    do_reset();
    idle(3);
    check32("pend_no_hit", hits_seen, 32'd0);
    tick(1'b1, 32'd2000, 32'd0);
    tick(1'b1, 32'd0, 32'd0);
    idle(3);
    check32("post_rst_hit", hits_seen, 32'd1);
    check32("post_rst_level", hit_level, 32'd2000);

    // Randomized segments against the model.
    for (int seg = 0; seg < 30; seg++) begin
      en = 1'b1;
      idle(4);
      if (seg % 6 == 0) do_reset();
      h0 = $urandom_range(0, 4);
      case (h0)
        0: thr = 32'd0;
        1: thr = $urandom_range(500, 5000);
        2: thr = $urandom_range(5000, 20000);
        3: thr = $urandom;
        default: thr = 32'd1000;
      endcase
      for (int i = 0; i < 60; i++) begin
        en = ($urandom_range(0, 7) != 0);
        tick($urandom_range(0, 3) != 0, rand_sample(), rand_sample());
      end
    end
    en = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_in_onset_detector.md
Name: audio_in_onset_detector

Overview:
- Reader/consumer side of the Audio_Controller capture interface: pops stereo ADC samples whenever available and turns them into drum-trigger events.
- Rectifies each sample pair, tracks a peak envelope with exponential decay, and runs a threshold/peak/holdoff state machine.
- Emits a one-cycle hit pulse plus the captured peak level, so a mic or pad on line-in can trigger drum-machine voices.

Parameters:
- DECAY_SHIFT, 4, envelope release: env decreases by env>>DECAY_SHIFT per sample.
- HOLDOFF_SAMPLES, 4800, samples ignored after a hit (100 ms at 48 kHz); must be >= 1.
- PEAK_MAX_SAMPLES, 96, maximum samples spent in PEAK before a hit is forced.

Ports:
- CLOCK_50 in 1: system clock; all logic on rising edge.
- reset in 1: asynchronous, active-high; clears all state.
- enable in 1: when low, no samples are popped and all state holds.
- threshold in 32: unsigned trigger level, compared against the envelope.
- audio_in_available in 1: capture FIFO non-empty. Data is valid show-ahead while this is high.
- left_channel_audio_in in 32: signed left sample.
- right_channel_audio_in in 32: signed right sample.
- read_audio_in out 1: pop strobe to the capture FIFO.
- envelope out 32: current unsigned envelope.
- hit out 1: one-cycle pulse per detected onset.
- hit_level out 32: peak envelope of the last hit; held until the next hit.
- busy out 1: high in any state other than ARMED.

Behaviour:
- **Reset values:** read_audio_in=0, envelope=0, hit=0, hit_level=0, busy=0. State=ARMED; all counters and pipeline valids are 0.
- **Pop handshake:**
  - read_audio_in = audio_in_available & enable & ~reset (combinational).
  - Data is captured in the same cycle read_audio_in is high. Exactly one sample pair is consumed per high cycle; back-to-back pops are allowed.
- **Stage 1 (cycle N+1 after pop cycle N):**
  - |L| and |R| computed in two's complement; 0x80000000 saturates to 0x7FFFFFFF.
  - mag = max(|L|,|R|); v1 set.
- **Stage 2 (N+2), only when v1:**
  - If mag > env: env <= mag.
  - Else: env <= env - (env >> DECAY_SHIFT), where env >> DECAY_SHIFT is a logical shift.
  - env therefore never underflows. Below 2^DECAY_SHIFT the decrement is 0 and env holds.
  - envelope output = env register; v2 set.
- **FSM:** advances only on v2 strobes (sample-rate, not clock-rate). hit is registered; it goes high at N+3 for the deciding sample.
  - ARMED: env >= threshold -> PEAK, pk <= env, pcnt <= 1.
  - PEAK, on each strobe:
    - If env >= pk: pk <= env and pcnt++.
    - If env < pk, or pcnt == PEAK_MAX_SAMPLES: hit <= 1, hit_level <= pk, hcnt <= 0, go to HOLDOFF.
  - HOLDOFF: hcnt++ per strobe. When hcnt reaches HOLDOFF_SAMPLES-1 -> REARM.
  - REARM: env < (threshold >> 1) -> ARMED (hysteresis); otherwise stay.
- **threshold:** sampled every strobe; a change takes effect on the next strobe.
- **threshold == 0:** the envelope always qualifies. A hit occurs at most once per holdoff, and REARM never exits because env < 0 is impossible; this is the defined behaviour.
- **enable deasserted mid-operation:** no further pops. In-flight pipeline stages complete, FSM and counters then freeze; resume seamlessly.
- **Asynchronous reset mid-operation:** immediate return to reset values, including during a pending hit.
- **Boundaries:** counters are sized to their parameter and never wrap. Comparisons are unsigned 32-bit.

Test Plan:
- **Handshake:** available high 5 cycles with enable=1 -> read_audio_in high exactly those 5 cycles, 5 pairs consumed. Same with enable=0 -> read_audio_in stays 0, envelope unchanged.
- **Rectify/saturate:** L=0x80000000, R=5 -> envelope=0x7FFFFFFF two cycles after the pop. L=-1000, R=700 -> envelope=1000.
- **Decay:** env=1600, then 3 zero samples with DECAY_SHIFT=4 -> 1500, 1407, 1320. env=10 with zero input -> holds at 10.
- **Onset:** threshold=1000; mags 0,500,2000,3000,2500 -> single hit pulse 3 cycles after the 2500 sample is popped, hit_level=3000, busy=1.
- **Holdoff/rearm:** HOLDOFF_SAMPLES=4; after a hit, feed a loud sample within 4 samples -> no hit. Then hold env >= 500 -> stays REARM. Drop below 500, then exceed 1000 -> second hit.
- **Reset:** assert reset while in PEAK -> hit never pulses, envelope=0, busy=0 asynchronously. After release, the first qualifying sample triggers normally.
